// File: rtl/ysyx_220066_lsu.sv
// Multi-cycle load/store unit: decodes MemOp and builds lane masks, runs one
// valid/ready transaction on a stallable memory port, and returns extended load data.
module ysyx_220066_lsu #(
   parameter int XLEN    = 64,
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_err
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ready_q;
   logic                wr_q, wr_d;
   logic [2:0]          op_q, op_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [NB-1:0]       wmask_q, wmask_d;
   logic                rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;

   // Request decode, evaluated against the live request fields in IDLE.
   logic [OFF_W-1:0]    req_off;
   logic [7:0]          lane8;
   logic [2:0]          size_m1_3;
   logic [NB-1:0]       req_lanes;
   logic [XLEN-1:0]     wd_masked;
   logic                req_illegal;

   always_comb begin
      req_off = req_addr[OFF_W-1:0];
      case (req_op[1:0])
         2'b00:   begin lane8 = 8'h01; size_m1_3 = 3'd0; end
         2'b01:   begin lane8 = 8'h03; size_m1_3 = 3'd1; end
         2'b10:   begin lane8 = 8'h0F; size_m1_3 = 3'd3; end
         default: begin lane8 = 8'hFF; size_m1_3 = 3'd7; end
      endcase
      req_lanes = lane8[NB-1:0];
      for (int i = 0; i < NB; i++) begin
         wd_masked[8*i +: 8] = req_lanes[i] ? req_wdata[8*i +: 8] : 8'h00;
      end
      req_illegal = (req_op == 3'b111)
                  | ((XLEN == 32) & ((req_op[1:0] == 2'b11) | (req_op == 3'b110)))
                  | (|(req_off & size_m1_3[OFF_W-1:0]))
                  | (req_wr & req_op[2]);
   end

   // Load extraction from the aligned word returned by memory.
   logic [XLEN-1:0]     rd_shift;
   logic [63:0]         keep64;
   logic [XLEN-1:0]     keep;
   logic                sbit;
   logic [XLEN-1:0]     ld_data;

   always_comb begin
      rd_shift = mem_rdata >> {off_q, 3'b000};
      case (op_q[1:0])
         2'b00:   begin keep64 = 64'h0000_0000_0000_00FF; sbit = rd_shift[7];      end
         2'b01:   begin keep64 = 64'h0000_0000_0000_FFFF; sbit = rd_shift[15];     end
         2'b10:   begin keep64 = 64'h0000_0000_FFFF_FFFF; sbit = rd_shift[31];     end
         default: begin keep64 = 64'hFFFF_FFFF_FFFF_FFFF; sbit = rd_shift[XLEN-1]; end
      endcase
      keep    = keep64[XLEN-1:0];
      ld_data = (rd_shift & keep) | ((~op_q[2] & sbit) ? ~keep : '0);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      op_d        = op_q;
      off_d       = off_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && ready_q) begin
               wr_d        = req_wr;
               op_d        = req_op;
               off_d       = req_off;
               addr_d      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               wdata_d     = req_wr ? (wd_masked << {req_off, 3'b000}) : '0;
               wmask_d     = req_wr ? (req_lanes << req_off) : '0;
               rsp_rdata_d = '0;
               cnt_d       = '0;
               if (req_illegal) begin
                  state_d   = S_DONE;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d   = S_BUSY;
                  rsp_err_d = 1'b0;
               end
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               state_d     = S_DONE;
               rsp_err_d   = mem_err;
               rsp_rdata_d = (!wr_q && !mem_err) ? ld_data : '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // A timed-out request is abandoned; a late mem_ready lands outside BUSY.
               if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
                  state_d     = S_DONE;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end
            end
         end
         S_DONE: begin
            state_d     = S_IDLE;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         wr_q        <= 1'b0;
         op_q        <= 3'b000;
         off_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= (state_d == S_IDLE);
         wr_q        <= wr_d;
         op_q        <= op_d;
         off_q       <= off_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   logic busy;
   assign busy      = (state_q == S_BUSY);
   assign req_ready = ready_q;
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_valid = busy;
   assign mem_wr    = busy & wr_q;
   assign mem_addr  = {ADDR_W{busy}} & addr_q;
   assign mem_wdata = {XLEN{busy}} & wdata_q;
   assign mem_wmask = {NB{busy}} & wmask_q;

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Bench for ysyx_220066_lsu: directed vector table, random traffic against a
// byte-level reference model, plus reset, timeout and XLEN=32 sequences.
module tb_ysyx_220066_lsu;

   logic        clk;
   logic        rst;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Main instance: XLEN=64, default timeout
   logic        req_valid, req_ready, req_wr;
   logic [2:0]  req_op;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [63:0] rsp_rdata;
   logic        mem_valid, mem_ready, mem_wr, mem_err;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   // Timeout instance: XLEN=64, TIMEOUT=4, shares request fields and read data
   logic        t_req_valid, t_req_ready, t_rsp_valid, t_rsp_err;
   logic [63:0] t_rsp_rdata, t_mem_addr, t_mem_wdata;
   logic        t_mem_valid, t_mem_ready, t_mem_wr;
   logic [7:0]  t_mem_wmask;

   // XLEN=32 instance
   logic        s_req_valid, s_req_ready, s_req_wr;
   logic [2:0]  s_req_op;
   logic [63:0] s_req_addr, s_mem_addr;
   logic [31:0] s_req_wdata, s_rsp_rdata, s_mem_wdata, s_mem_rdata;
   logic        s_rsp_valid, s_rsp_err, s_mem_valid, s_mem_ready, s_mem_wr, s_mem_err;
   logic [3:0]  s_mem_wmask;

   ysyx_220066_lsu #(.XLEN(64), .ADDR_W(64), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   ysyx_220066_lsu #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) dut_t (
      .clk(clk), .rst(rst),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_wr(req_wr), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
      .mem_valid(t_mem_valid), .mem_ready(t_mem_ready), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr),
      .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   ysyx_220066_lsu #(.XLEN(32), .ADDR_W(64), .TIMEOUT(255)) dut_s (
      .clk(clk), .rst(rst),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wr(s_req_wr), .req_op(s_req_op),
      .req_addr(s_req_addr), .req_wdata(s_req_wdata),
      .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
      .mem_valid(s_mem_valid), .mem_ready(s_mem_ready), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask), .mem_rdata(s_mem_rdata), .mem_err(s_mem_err)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model (XLEN=64): byte-by-byte view of a single access.
   function automatic void ref_model(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                                     input logic [63:0] wdata, input logic [63:0] rdata,
                                     input bit merr, output bit err, output bit issue,
                                     output logic [63:0] rd, output logic [7:0] wm,
                                     output logic [63:0] wd);
      int size = 1 << op[1:0];
      int off  = int'(addr % 8);
      longint unsigned v = 0;
      bit illegal = (op == 3'b111) || (wr && op[2]) || ((off % size) != 0);
      issue = !illegal;
      err   = illegal || merr;
      rd = '0; wm = '0; wd = '0;
      if (issue && wr) begin
         for (int b = 0; b < size; b++) begin
            wm[off + b] = 1'b1;
            wd[8*(off + b) +: 8] = wdata[8*b +: 8];
         end
      end else if (issue && !merr) begin
         for (int b = 0; b < size; b++) v = v | (longint'(rdata[8*(off + b) +: 8]) << (8*b));
         if (!op[2] && size < 8 && v >= (64'd1 << (8*size - 1))) v = v - (64'd1 << (8*size));
         rd = v;
      end
   endfunction

   // Driver for the main instance: one full transaction with wt wait cycles.
   task automatic do_txn(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input bit merr,
                         input int wt, input bit e_err, input bit e_issue,
                         input logic [63:0] e_rd, input logic [7:0] e_wm,
                         input logic [63:0] e_wd, input string tag);
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      chk({tag, ".req_ready_idle"}, req_ready, 1);
      req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, ".req_ready_busy"}, req_ready, 0);
      if (!e_issue) begin
         chk({tag, ".mem_valid"}, mem_valid, 0);
         chk({tag, ".rsp_valid"}, rsp_valid, 1);
         chk({tag, ".rsp_err"}, rsp_err, 1);
         chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
      end else begin
         for (int k = 0; k <= wt; k++) begin
            chk({tag, ".mem_valid"}, mem_valid, 1);
            chk({tag, ".mem_wr"}, mem_wr, wr);
            chk({tag, ".mem_addr"}, mem_addr, addr & ~64'h7);
            chk({tag, ".mem_wmask"}, mem_wmask, e_wm);
            if (wr) chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
            chk({tag, ".rsp_valid_wait"}, rsp_valid, 0);
            if (k == wt) begin
               mem_ready = 1'b1; mem_rdata = rdata; mem_err = merr;
            end else begin
               mem_ready = 1'b0; mem_rdata = ~rdata; mem_err = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
         end
         mem_ready = 1'b0; mem_err = 1'b0;
         chk({tag, ".rsp_valid"}, rsp_valid, 1);
         chk({tag, ".rsp_err"}, rsp_err, e_err);
         chk({tag, ".rsp_rdata"}, rsp_rdata, e_rd);
         chk({tag, ".mem_valid_done"}, mem_valid, 0);
      end
      @(negedge clk);
      chk({tag, ".rsp_valid_pulse"}, rsp_valid, 0);
      chk({tag, ".req_ready_back"}, req_ready, 1);
   endtask

   // Driver for the XLEN=32 instance (zero wait states).
   task automatic s_txn(input bit wr, input logic [2:0] op, input logic [63:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input bit e_err,
                        input logic [31:0] e_rd, input logic [3:0] e_wm,
                        input logic [31:0] e_wd, input string tag);
      for (int i = 0; i < 20 && !s_req_ready; i++) @(negedge clk);
      chk({tag, ".req_ready_idle"}, s_req_ready, 1);
      s_req_valid = 1'b1; s_req_wr = wr; s_req_op = op; s_req_addr = addr; s_req_wdata = wdata;
      @(negedge clk);
      s_req_valid = 1'b0;
      if (e_err) begin
         chk({tag, ".mem_valid"}, s_mem_valid, 0);
         chk({tag, ".rsp_valid"}, s_rsp_valid, 1);
         chk({tag, ".rsp_err"}, s_rsp_err, 1);
      end else begin
         chk({tag, ".mem_valid"}, s_mem_valid, 1);
         chk({tag, ".mem_addr"}, s_mem_addr, addr & ~64'h3);
         chk({tag, ".mem_wmask"}, s_mem_wmask, e_wm);
         if (wr) chk({tag, ".mem_wdata"}, s_mem_wdata, e_wd);
         s_mem_ready = 1'b1; s_mem_rdata = rdata;
         @(negedge clk);
         s_mem_ready = 1'b0;
         chk({tag, ".rsp_valid"}, s_rsp_valid, 1);
         chk({tag, ".rsp_err"}, s_rsp_err, 0);
         chk({tag, ".rsp_rdata"}, s_rsp_rdata, e_rd);
      end
      @(negedge clk);
      chk({tag, ".rsp_valid_pulse"}, s_rsp_valid, 0);
      chk({tag, ".req_ready_back"}, s_req_ready, 1);
   endtask

   typedef struct {
      bit          wr;
      logic [2:0]  op;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      bit          merr;
      int          wt;
      bit          err;
      bit          issue;
      logic [63:0] rd;
      logic [7:0]  wm;
      logic [63:0] wd;
   } vec_t;

   vec_t tbl[18];

   initial begin
      bit          r_err, r_issue, r_wr, r_merr;
      logic [2:0]  r_op;
      logic [63:0] r_addr, r_wdata, r_rdata, r_rd, r_wd;
      logic [7:0]  r_wm;
      int          r_wt;

      //          wr    op      addr              wdata                  rdata                  merr  wt err   issue rd                     wm     wd
      tbl[0]  = '{1'b0, 3'b000, 64'h8000_0003, 64'h0,                 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF85, 8'h00, 64'h0};
      tbl[1]  = '{1'b0, 3'b100, 64'h8000_0003, 64'h0,                 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0, 1'b1, 64'h0000_0000_0000_0085, 8'h00, 64'h0};
      tbl[2]  = '{1'b1, 3'b001, 64'h8000_0006, 64'h1234_ABCD,         64'h0,                   1'b0, 0, 1'b0, 1'b1, 64'h0,                   8'hC0, 64'hABCD_0000_0000_0000};
      tbl[3]  = '{1'b0, 3'b010, 64'h8000_0002, 64'h0,                 64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0,                   8'h00, 64'h0};
      tbl[4]  = '{1'b0, 3'b011, 64'h8000_0008, 64'h0,                 64'hDEAD_BEEF_0123_4567, 1'b0, 5, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0};
      tbl[5]  = '{1'b1, 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0,                 1'b0, 2, 1'b0, 1'b1, 64'h0,                   8'hFF, 64'h0123_4567_89AB_CDEF};
      tbl[6]  = '{1'b0, 3'b001, 64'h8000_0002, 64'h0,                 64'h1122_3344_8566_7788, 1'b0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8566, 8'h00, 64'h0};
      tbl[7]  = '{1'b0, 3'b101, 64'h8000_0002, 64'h0,                 64'h1122_3344_8566_7788, 1'b0, 1, 1'b0, 1'b1, 64'h0000_0000_0000_8566, 8'h00, 64'h0};
      tbl[8]  = '{1'b0, 3'b010, 64'h8000_0004, 64'h0,                 64'h8000_0001_0000_0000, 1'b0, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001, 8'h00, 64'h0};
      tbl[9]  = '{1'b0, 3'b110, 64'h8000_0004, 64'h0,                 64'h8000_0001_0000_0000, 1'b0, 0, 1'b0, 1'b1, 64'h0000_0000_8000_0001, 8'h00, 64'h0};
      tbl[10] = '{1'b0, 3'b111, 64'h8000_0000, 64'h0,                 64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0,                   8'h00, 64'h0};
      tbl[11] = '{1'b1, 3'b100, 64'h8000_0000, 64'hFF,                64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0,                   8'h00, 64'h0};
      tbl[12] = '{1'b0, 3'b011, 64'h8000_0018, 64'h0,                 64'h5555_5555_5555_5555, 1'b1, 1, 1'b1, 1'b1, 64'h0,                   8'h00, 64'h0};
      tbl[13] = '{1'b1, 3'b010, 64'h8000_0004, 64'hFFFF_FFFF_CAFE_BABE, 64'h0,                 1'b0, 0, 1'b0, 1'b1, 64'h0,                   8'hF0, 64'hCAFE_BABE_0000_0000};
      tbl[14] = '{1'b1, 3'b000, 64'h8000_0007, 64'h0000_0000_0000_12AB, 64'h0,                 1'b0, 3, 1'b0, 1'b1, 64'h0,                   8'h80, 64'hAB00_0000_0000_0000};
      tbl[15] = '{1'b0, 3'b001, 64'h8000_0001, 64'h0,                 64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0,                   8'h00, 64'h0};
      tbl[16] = '{1'b0, 3'b011, 64'h8000_0004, 64'h0,                 64'h0,                   1'b0, 0, 1'b1, 1'b0, 64'h0,                   8'h00, 64'h0};
      tbl[17] = '{1'b1, 3'b000, 64'h8000_0000, 64'h0000_0000_0000_00FF, 64'h0,                 1'b1, 0, 1'b1, 1'b1, 64'h0,                   8'h01, 64'h0000_0000_0000_00FF};

      rst = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      t_req_valid = 1'b0; t_mem_ready = 1'b0;
      s_req_valid = 1'b0; s_req_wr = 1'b0; s_req_op = 3'b000; s_req_addr = '0; s_req_wdata = '0;
      s_mem_ready = 1'b0; s_mem_rdata = '0; s_mem_err = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.req_ready", req_ready, 0);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_err", rsp_err, 0);
      chk("rst.rsp_rdata", rsp_rdata, 0);
      chk("rst.mem_valid", mem_valid, 0);
      chk("rst.mem_wr", mem_wr, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.mem_wmask", mem_wmask, 0);
      rst = 1'b0;
      #1;
      chk("rst.req_ready_before_edge", req_ready, 0);
      @(negedge clk);
      chk("rst.req_ready_after_edge", req_ready, 1);

      // mem_ready while idle must not produce a response
      mem_ready = 1'b1; mem_err = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ready.rsp_valid", rsp_valid, 0);
         chk("idle_ready.mem_valid", mem_valid, 0);
         chk("idle_ready.req_ready", req_ready, 1);
      end
      mem_ready = 1'b0; mem_err = 1'b0;

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         do_txn(tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].merr,
                tbl[i].wt, tbl[i].err, tbl[i].issue, tbl[i].rd, tbl[i].wm, tbl[i].wd,
                $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of BUSY
      req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011; req_addr = 64'h8000_0020;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_busy.mem_valid_before", mem_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy.mem_valid_async", mem_valid, 0);
      chk("rst_busy.req_ready_async", req_ready, 0);
      chk("rst_busy.rsp_valid_async", rsp_valid, 0);
      @(negedge clk);
      chk("rst_busy.rsp_valid_held", rsp_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy.rsp_valid_after", rsp_valid, 0);
      chk("rst_busy.req_ready_after", req_ready, 1);
      do_txn(1'b0, 3'b011, 64'h8000_0028, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 0,
             1'b0, 1'b1, 64'h0102_0304_0506_0708, 8'h00, 64'h0, "post_rst_ld");

      // Random traffic against the reference model
      for (int n = 0; n < 200; n++) begin
         r_wr    = 1'($urandom_range(0, 1));
         r_op    = 3'($urandom_range(0, 7));
         r_addr  = 64'h8000_0000 + 64'($urandom_range(0, 63));
         r_wdata = {$urandom, $urandom};
         r_rdata = {$urandom, $urandom};
         r_merr  = ($urandom_range(0, 9) == 0);
         r_wt    = $urandom_range(0, 4);
         ref_model(r_wr, r_op, r_addr, r_wdata, r_rdata, r_merr, r_err, r_issue, r_rd, r_wm, r_wd);
         do_txn(r_wr, r_op, r_addr, r_wdata, r_rdata, r_merr, r_wt, r_err, r_issue, r_rd, r_wm,
                r_wd, $sformatf("rnd%0d", n));
      end

      // Timeout instance (TIMEOUT=4, memory never answers in time)
      chk("tmo.req_ready_idle", t_req_ready, 1);
      t_req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011; req_addr = 64'h8000_0040;
      @(negedge clk);
      t_req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("tmo.mem_valid%0d", k), t_mem_valid, 1);
         chk($sformatf("tmo.mem_addr%0d", k), t_mem_addr, 64'h8000_0040);
         chk($sformatf("tmo.rsp_valid%0d", k), t_rsp_valid, 0);
         @(negedge clk);
      end
      chk("tmo.rsp_valid", t_rsp_valid, 1);
      chk("tmo.rsp_err", t_rsp_err, 1);
      chk("tmo.rsp_rdata", t_rsp_rdata, 0);
      chk("tmo.mem_valid_done", t_mem_valid, 0);
      t_mem_ready = 1'b1;
      @(negedge clk);
      chk("tmo.rsp_valid_pulse", t_rsp_valid, 0);
      chk("tmo.mem_valid_after", t_mem_valid, 0);
      chk("tmo.req_ready_back", t_req_ready, 1);
      @(negedge clk);
      t_mem_ready = 1'b0;
      chk("tmo.late_ready_ignored", t_rsp_valid, 0);

      // XLEN=32 instance
      s_txn(1'b0, 3'b011, 64'h8000_0000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, "x32_ld");
      s_txn(1'b0, 3'b110, 64'h8000_0000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, "x32_lwu");
      s_txn(1'b0, 3'b010, 64'h8000_0004, 32'h0, 32'h8000_0001, 1'b0, 32'h8000_0001, 4'h0, 32'h0, "x32_lw");
      s_txn(1'b0, 3'b000, 64'h8000_0003, 32'h0, 32'h8566_7788, 1'b0, 32'hFFFF_FF85, 4'h0, 32'h0, "x32_lb");
      s_txn(1'b1, 3'b001, 64'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0, 32'h0, 4'hC, 32'hABCD_0000, "x32_sh");
      s_txn(1'b0, 3'b010, 64'h8000_0006, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, "x32_lw_mis");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_220066_lsu.md
# ysyx_220066_lsu

Parametrised, multi-cycle load/store unit for the ysyx_220066 core. It replaces the single-cycle, zero-wait data-memory path with a valid/ready transaction against a memory port that may stall. It generates byte-lane masks, aligns write data and extracts and extends read data per MemOp. It also detects misaligned or illegal accesses and memory timeouts. It sits between EX (address/store data) and the writeback mux.

## Interface
Parameters:
- XLEN, 64, data width; 32 or 64.
- ADDR_W, 64, address width.
- TIMEOUT, 255, max BUSY cycles waiting for mem_ready before error; 0 disables timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  EX presents an access.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_op  in  3  MemOp (RISC-V funct3): 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal op, mem_err or timeout.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory completes request this cycle.
- mem_wr  out  1  store.
- mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_wmask  out  XLEN/8  byte enables; 0 for loads.
- mem_rdata  in  XLEN  full aligned word.
- mem_err  in  1  bus error, sampled with mem_ready.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - BUSY: mem_valid=1.
  - DONE: rsp_valid=1, req_ready=0.
- IDLE, on req_valid:
  - Latch all request fields.
  - size = 1 << req_op[1:0]; off = req_addr mod (XLEN/8).
  - Error if any of: req_op==111; req_op[1:0]==11 with XLEN==32; req_op==110 with XLEN==32; off mod size != 0; req_wr with req_op[2]==1.
  - Error: go DONE with rsp_err=1, no memory request.
  - Otherwise: go BUSY, clear the timeout counter.
- BUSY:
  - mem_valid, mem_wr, mem_addr, mem_wdata and mem_wmask are held constant until mem_ready.
  - mem_wmask = ((1<<size)-1) << off.
  - mem_wdata = (req_wdata masked to size) << 8*off.
  - On mem_ready: capture rsp_err=mem_err.
  - For loads without mem_err: rsp_rdata = mem_rdata >> 8*off, truncated to size, sign-extended if req_op[2]==0, else zero-extended.
  - Then go DONE.
  - Without mem_ready, the counter increments each cycle. When counter==TIMEOUT (TIMEOUT>0): go DONE with rsp_err=1, rsp_rdata=0. mem_valid drops and the late mem_ready is ignored.
- DONE: rsp_valid for exactly one cycle, unconditional (no backpressure); then IDLE.
- Little-endian throughout. 8-byte accesses for XLEN=64 use off=0 only.
- Reset values (and all values while rst high):
  - state=IDLE, counter=0.
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
  - req_ready rises the first cycle after rst deasserts.

## Timing
- Accept at edge E (req_valid & req_ready).
- mem_valid is high in the cycle after E.
- If mem_ready is high in the first BUSY cycle, rsp_valid is high in the following cycle. Minimum accept-to-response: 2 edges.
- N wait cycles add N cycles to the response.
- Error detected at accept: rsp_valid in the cycle after E, 1 edge.
- Throughput:
  - Valid request: one access per 3 cycles minimum (IDLE, BUSY, DONE).
  - Error case: one per 2 cycles.
- Reset mid-BUSY: mem_valid drops asynchronously. The memory must tolerate the abandoned request. No rsp_valid is produced for it.
- mem_ready outside BUSY is ignored.
- rsp outputs are registered; the mem_* outputs are registered or decoded from registered state only. There are no combinational paths from req_* to mem_*.

## Test plan
- XLEN=64, lb at 0x8000_0003, mem_rdata=0x1122_3344_8566_7788, mem_ready in first BUSY cycle -> mem_addr=0x8000_0000, mem_wmask=0x00, rsp_rdata=0xFFFF_FFFF_FFFF_FF85. Same with lbu -> 0x0000_0000_0000_0085. rsp_valid 2 edges after accept.
- sh at 0x8000_0006, req_wdata=0x1234_ABCD -> mem_wmask=0xC0, mem_wdata=0xABCD_0000_0000_0000, rsp_rdata=0, rsp_err=0.
- lw at 0x8000_0002 -> no mem_valid ever; rsp_valid, rsp_err=1 one cycle after accept; req_ready back next cycle.
- mem_ready delayed 5 cycles -> mem_addr/mem_wdata/mem_wmask stable all 6 BUSY cycles; rsp one cycle after mem_ready. With TIMEOUT=4 and no mem_ready -> rsp_err=1 after 4 BUSY cycles, mem_valid low afterwards.
- rst pulsed between clock edges during BUSY -> mem_valid and req_ready fall immediately without a clock edge; no rsp_valid. A following ld completes normally with rsp_err=0.
- XLEN=32, ld or lwu at an aligned address -> rsp_err=1, no memory request. lw at 0x...4 with mem_rdata=0x8000_0001 -> rsp_rdata=0x8000_0001.
